// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: ID/EX hazard sources in, stall/flush controls out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] i_id_rs1;
  logic [REG_AW-1:0] i_id_rs2;
  logic              i_id_rs1_used;
  logic              i_id_rs2_used;
  logic [REG_AW-1:0] i_ex_rd;
  logic              i_ex_mem_read;
  logic              i_ex_br_valid;
  logic              i_ex_br_taken;
  logic              i_ex_pred_taken;
  logic              i_wait_IM1_read;
  logic              i_wait_DM1;
  logic              i_wfi_ex;
  logic              i_irq_pending;
  logic              o_stall;
  logic              o_flush_ex;
  logic              o_nt_pt;
  logic              o_t_pnt;
  logic              o_wait_WFI;
  logic [CNT_W-1:0]  o_bubble_cnt;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used, i_ex_rd, i_ex_mem_read,
           i_ex_br_valid, i_ex_br_taken, i_ex_pred_taken, i_wait_IM1_read, i_wait_DM1,
           i_wfi_ex, i_irq_pending,
    input  o_stall, o_flush_ex, o_nt_pt, o_t_pnt, o_wait_WFI, o_bubble_cnt
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used, i_ex_rd, i_ex_mem_read,
           i_ex_br_valid, i_ex_br_taken, i_ex_pred_taken, i_wait_IM1_read, i_wait_DM1,
           i_wfi_ex, i_irq_pending,
    output o_stall, o_flush_ex, o_nt_pt, o_t_pnt, o_wait_WFI, o_bubble_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, mispredict, bus waits and WFI sleep,
// plus a saturating bubble counter.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned REG_AW = 5
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_WFI, S_WAKE} state_t;

  state_t           state, state_nx;
  logic             pend_nt, pend_tp, pend_nt_nx, pend_tp_nx;
  logic             hazard, mis, busy;
  logic             stall, flush, nt_pt, t_pnt, wait_wfi;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    hazard = bus.i_ex_mem_read && (bus.i_ex_rd != '0) &&
             ((bus.i_id_rs1_used && (bus.i_id_rs1 == bus.i_ex_rd)) ||
              (bus.i_id_rs2_used && (bus.i_id_rs2 == bus.i_ex_rd)));
    mis    = bus.i_ex_br_valid && (bus.i_ex_br_taken != bus.i_ex_pred_taken);
    busy   = bus.i_wait_DM1 || bus.i_wait_IM1_read;
  end

  always_comb begin
    state_nx   = state;
    pend_nt_nx = pend_nt;
    pend_tp_nx = pend_tp;
    stall      = 1'b0;
    flush      = 1'b0;
    nt_pt      = 1'b0;
    t_pnt      = 1'b0;
    wait_wfi   = 1'b0;
    unique case (state)
      S_RUN: begin
        if (bus.i_wait_DM1) begin
          stall = 1'b1;
          // EX is frozen during the wait, so a held branch is latched once and not re-counted
          if (mis && !pend_nt && !pend_tp) begin
            pend_nt_nx = bus.i_ex_pred_taken;
            pend_tp_nx = bus.i_ex_br_taken;
          end
        end else if (pend_nt || pend_tp) begin
          nt_pt      = pend_nt;
          t_pnt      = pend_tp;
          flush      = 1'b1;
          pend_nt_nx = 1'b0;
          pend_tp_nx = 1'b0;
        end else if (mis) begin
          nt_pt = bus.i_ex_pred_taken;
          t_pnt = bus.i_ex_br_taken;
          flush = 1'b1;
        end else if (hazard) begin
          stall = 1'b1;
          flush = 1'b1;
        end else if (bus.i_wfi_ex && !busy) begin
          stall    = 1'b1;
          state_nx = S_WFI;
        end
      end
      S_WFI: begin
        wait_wfi = 1'b1;
        stall    = 1'b1;
        if (bus.i_irq_pending) state_nx = S_WAKE;
      end
      S_WAKE: begin
        flush    = 1'b1;
        state_nx = S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RUN;
      pend_nt <= 1'b0;
      pend_tp <= 1'b0;
    end else begin
      state   <= state_nx;
      pend_nt <= pend_nt_nx;
      pend_tp <= pend_tp_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((flush || nt_pt || t_pnt) && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.o_stall      = stall;
  assign bus.o_flush_ex   = flush;
  assign bus.o_nt_pt      = nt_pt;
  assign bus.o_t_pnt      = t_pnt;
  assign bus.o_wait_WFI   = wait_wfi;
  assign bus.o_bubble_cnt = cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expected outputs are queued per cycle and checked at negedge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned REG_AW  = 5;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    string tag;
    logic  stall, flush, nt, tp, wfi;
    int    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W), .REG_AW(REG_AW)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.i_id_rs1        = '0;
    bus.i_id_rs2        = '0;
    bus.i_id_rs1_used   = 1'b0;
    bus.i_id_rs2_used   = 1'b0;
    bus.i_ex_rd         = '0;
    bus.i_ex_mem_read   = 1'b0;
    bus.i_ex_br_valid   = 1'b0;
    bus.i_ex_br_taken   = 1'b0;
    bus.i_ex_pred_taken = 1'b0;
    bus.i_wait_IM1_read = 1'b0;
    bus.i_wait_DM1      = 1'b0;
    bus.i_wfi_ex        = 1'b0;
    bus.i_irq_pending   = 1'b0;
  endtask

  task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Push the expected outputs for the cycle just driven, check them at negedge, advance a cycle.
  task automatic cyc(input string tag, input logic stall, input logic flush,
                     input logic nt, input logic tp, input logic wfi);
    exp_t e;
    e.tag = tag; e.stall = stall; e.flush = flush; e.nt = nt; e.tp = tp; e.wfi = wfi;
    e.cnt = exp_cnt;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    cmp(e.tag, "stall", 32'(bus.o_stall),      32'(e.stall));
    cmp(e.tag, "flush", 32'(bus.o_flush_ex),   32'(e.flush));
    cmp(e.tag, "nt_pt", 32'(bus.o_nt_pt),      32'(e.nt));
    cmp(e.tag, "t_pnt", 32'(bus.o_t_pnt),      32'(e.tp));
    cmp(e.tag, "wfi",   32'(bus.o_wait_WFI),   32'(e.wfi));
    cmp(e.tag, "cnt",   32'(bus.o_bubble_cnt), 32'(e.cnt));
    if ((flush || nt || tp) && !rst && exp_cnt < CNT_MAX) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string tag);
    rst     = 1'b1;
    exp_cnt = 0;
    idle_inputs();
    cyc(tag, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc("run_idle", 0, 0, 0, 0, 0);

    // load-use on rs2
    bus.i_ex_mem_read = 1'b1; bus.i_ex_rd = 5'd5;
    bus.i_id_rs2 = 5'd5; bus.i_id_rs2_used = 1'b1;
    cyc("loaduse_rs2", 1, 1, 0, 0, 0);
    idle_inputs();
    cyc("after_loaduse", 0, 0, 0, 0, 0);

    // x0 destination never hazards
    bus.i_ex_mem_read = 1'b1; bus.i_ex_rd = '0;
    bus.i_id_rs1 = '0; bus.i_id_rs1_used = 1'b1;
    cyc("lw_x0", 0, 0, 0, 0, 0);
    // matching index but operand unused
    bus.i_ex_rd = 5'd7; bus.i_id_rs1 = 5'd7; bus.i_id_rs1_used = 1'b0;
    cyc("rs1_unused", 0, 0, 0, 0, 0);
    bus.i_id_rs1_used = 1'b1;
    cyc("loaduse_rs1", 1, 1, 0, 0, 0);
    idle_inputs();

    // predicted taken, not taken
    bus.i_ex_br_valid = 1'b1; bus.i_ex_pred_taken = 1'b1; bus.i_ex_br_taken = 1'b0;
    bus.i_ex_mem_read = 1'b1; bus.i_ex_rd = 5'd3; bus.i_id_rs1 = 5'd3; bus.i_id_rs1_used = 1'b1;
    cyc("nt_pt_over_hazard", 0, 1, 1, 0, 0);
    idle_inputs();
    bus.i_ex_br_valid = 1'b1; bus.i_ex_pred_taken = 1'b1; bus.i_ex_br_taken = 1'b1;
    cyc("correct_pred", 0, 0, 0, 0, 0);
    idle_inputs();

    // mispredict held during a 3-cycle DM wait, served on the 4th
    bus.i_ex_br_valid = 1'b1; bus.i_ex_pred_taken = 1'b0; bus.i_ex_br_taken = 1'b1;
    bus.i_wait_DM1 = 1'b1;
    cyc("dm_wait1", 1, 0, 0, 0, 0);
    cyc("dm_wait2", 1, 0, 0, 0, 0);
    cyc("dm_wait3", 1, 0, 0, 0, 0);
    bus.i_wait_DM1 = 1'b0;
    bus.i_ex_pred_taken = 1'b1; bus.i_ex_br_taken = 1'b0;
    cyc("pend_first", 0, 1, 0, 1, 0);
    idle_inputs();
    cyc("pend_cleared", 0, 0, 0, 0, 0);

    // load-use during DM wait: stall only
    bus.i_wait_DM1 = 1'b1;
    bus.i_ex_mem_read = 1'b1; bus.i_ex_rd = 5'd9; bus.i_id_rs2 = 5'd9; bus.i_id_rs2_used = 1'b1;
    cyc("hazard_in_dm", 1, 0, 0, 0, 0);
    idle_inputs();

    // fetch wait alone does not stall, and blocks WFI entry
    bus.i_wait_IM1_read = 1'b1;
    cyc("im_wait", 0, 0, 0, 0, 0);
    bus.i_wfi_ex = 1'b1;
    cyc("wfi_busy", 0, 0, 0, 0, 0);
    idle_inputs();
    cyc("no_wfi_entry", 0, 0, 0, 0, 0);

    // WFI, irq on the 6th sleep cycle, stray branch ignored while asleep
    bus.i_wfi_ex = 1'b1;
    cyc("wfi_enter", 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      bus.i_ex_br_valid = (i == 3); bus.i_ex_br_taken = (i == 3);
      cyc($sformatf("wfi_sleep%0d", i), 1, 0, 0, 0, 1);
    end
    bus.i_ex_br_valid = 1'b0; bus.i_ex_br_taken = 1'b0;
    bus.i_irq_pending = 1'b1;
    cyc("wfi_sleep6", 1, 0, 0, 0, 1);
    idle_inputs();
    cyc("wake", 0, 1, 0, 0, 0);
    cyc("post_wake", 0, 0, 0, 0, 0);

    // irq together with WFI entry still sleeps one cycle
    bus.i_wfi_ex = 1'b1; bus.i_irq_pending = 1'b1;
    cyc("wfi_irq_enter", 1, 0, 0, 0, 0);
    bus.i_wfi_ex = 1'b0;
    cyc("wfi_min_sleep", 1, 0, 0, 0, 1);
    cyc("wake2", 0, 1, 0, 0, 0);
    idle_inputs();
    cyc("post_wake2", 0, 0, 0, 0, 0);

    // saturate the bubble counter with back-to-back load-use hazards
    bus.i_ex_mem_read = 1'b1; bus.i_ex_rd = 5'd31; bus.i_id_rs1 = 5'd31; bus.i_id_rs1_used = 1'b1;
    for (int i = 0; i < 16; i++) cyc($sformatf("sat%0d", i), 1, 1, 0, 0, 0);
    idle_inputs();
    cyc("sat_hold", 0, 0, 0, 0, 0);

    // reset with a pending mispredict
    bus.i_wait_DM1 = 1'b1;
    bus.i_ex_br_valid = 1'b1; bus.i_ex_pred_taken = 1'b0; bus.i_ex_br_taken = 1'b1;
    cyc("pend_before_rst", 1, 0, 0, 0, 0);
    async_reset("rst_pending");
    cyc("pend_gone", 0, 0, 0, 0, 0);

    // reset in WFI
    bus.i_wfi_ex = 1'b1;
    cyc("wfi_enter3", 1, 0, 0, 0, 0);
    bus.i_wfi_ex = 1'b0;
    cyc("wfi_sleep_r", 1, 0, 0, 0, 1);
    async_reset("rst_in_wfi");
    cyc("run_after_rst", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
